store_buffer_q: RTL and testbench

STORE_BUFFER_Q -- requirements
Module: store_buffer_q

---
 rtl/store_buffer_q_if.sv | 42 ++++
 rtl/store_buffer_q.sv | 100 ++++++++++
 tb/tb_store_buffer_q.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_q_if.sv
// store_buffer_q_if: allocate/commit/flush, memory-drain, load-lookup and status signals of the store buffer.
interface store_buffer_q_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CW     = $clog2(DEPTH) + 1;
    logic              alloc_valid_i;
    logic              alloc_ready_o;
    logic [ADDR_W-1:0] alloc_addr_i;
    logic [DATA_W-1:0] alloc_data_i;
    logic [STRB_W-1:0] alloc_strb_i;
    logic              commit_i;
    logic              flush_i;
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [STRB_W-1:0] mem_strb_o;
    logic              ld_valid_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic              ld_hit_o;
    logic [DATA_W-1:0] ld_data_o;
    logic [STRB_W-1:0] ld_strb_o;
    logic [CW-1:0]     count_o;
    logic              full_o;
    logic              empty_o;

    modport master (
        output alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_strb_i, commit_i, flush_i,
               mem_ready_i, ld_valid_i, ld_addr_i,
        input  alloc_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_strb_o,
               ld_hit_o, ld_data_o, ld_strb_o, count_o, full_o, empty_o
    );
    modport slave (
        input  alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_strb_i, commit_i, flush_i,
               mem_ready_i, ld_valid_i, ld_addr_i,
        output alloc_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_strb_o,
               ld_hit_o, ld_data_o, ld_strb_o, count_o, full_o, empty_o
    );
endinterface

// File: rtl/store_buffer_q.sv
// store_buffer_q: circular store buffer with head/commit/tail pointers and in-order memory drain.
// Load forwarding (youngest matching entry, registered result) is built only with STORE_BUFFER_FWD_EN.
module store_buffer_q #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic            clk_i,
    input logic            reset_n_i,
    store_buffer_q_if.slave sb
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IW     = $clog2(DEPTH);
    localparam int PW     = IW + 1;
    localparam int OFF    = $clog2(STRB_W);

    logic [PW-1:0]     head, cmt, tail, cnt;
    logic [ADDR_W-1:0] addr_m [DEPTH];
    logic [DATA_W-1:0] data_m [DEPTH];
    logic [STRB_W-1:0] strb_m [DEPTH];
    logic              full, mem_valid, do_alloc, do_commit, do_drain;

    assign cnt       = tail - head;
    assign full      = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
    assign mem_valid = head != cmt;
    assign do_alloc  = sb.alloc_valid_i && !full && !sb.flush_i;
    assign do_commit = sb.commit_i && (cmt != tail);
    assign do_drain  = mem_valid && sb.mem_ready_i;

    assign sb.count_o       = cnt;
    assign sb.full_o        = full;
    assign sb.empty_o       = head == tail;
    assign sb.alloc_ready_o = !full;
    assign sb.mem_valid_o   = mem_valid;
    assign sb.mem_addr_o    = addr_m[head[IW-1:0]];
    assign sb.mem_data_o    = data_m[head[IW-1:0]];
    assign sb.mem_strb_o    = strb_m[head[IW-1:0]];

    // flush rolls tail back onto the commit pointer as it stands after this edge's commit
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
        end else begin
            head <= head + PW'(do_drain);
            cmt  <= cmt + PW'(do_commit);
            tail <= sb.flush_i ? cmt + PW'(do_commit) : tail + PW'(do_alloc);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_alloc) begin
            addr_m[tail[IW-1:0]] <= sb.alloc_addr_i;
            data_m[tail[IW-1:0]] <= sb.alloc_data_i;
            strb_m[tail[IW-1:0]] <= sb.alloc_strb_i;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic              hit_c;
    logic [DATA_W-1:0] data_c;
    logic [STRB_W-1:0] strb_c;
    logic [IW-1:0]     idx;

    // walk oldest to youngest so the youngest match overrides earlier ones
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        strb_c = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head[IW-1:0] + IW'(k);
            if (PW'(k) < cnt && addr_m[idx][ADDR_W-1:OFF] == sb.ld_addr_i[ADDR_W-1:OFF]) begin
                hit_c  = 1'b1;
                data_c = data_m[idx];
                strb_c = strb_m[idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sb.ld_hit_o  <= 1'b0;
            sb.ld_data_o <= '0;
            sb.ld_strb_o <= '0;
        end else begin
            sb.ld_hit_o  <= sb.ld_valid_i && hit_c;
            sb.ld_data_o <= (sb.ld_valid_i && hit_c) ? data_c : '0;
            sb.ld_strb_o <= (sb.ld_valid_i && hit_c) ? strb_c : '0;
        end
    end
`else
    logic unused_ld;
    assign unused_ld    = ^{sb.ld_valid_i, sb.ld_addr_i};
    assign sb.ld_hit_o  = 1'b0;
    assign sb.ld_data_o = '0;
    assign sb.ld_strb_o = '0;
`endif
endmodule

// File: tb/tb_store_buffer_q.sv
// tb_store_buffer_q: directed scenarios plus randomized traffic checked against a queue-based store buffer model.
module tb_store_buffer_q;
    localparam int DEPTH = 8;
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    store_buffer_q_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) sb();
    store_buffer_q #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .sb(sb)
    );

    ent_t        q[$];
    int          nc, dut_wr, n_chk, n_pass;
    bit          eh;
    logic [31:0] ed;
    logic [3:0]  es;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all();
        check("count", sb.count_o, q.size());
        check("full", sb.full_o, q.size() == DEPTH);
        check("empty", sb.empty_o, q.size() == 0);
        check("alloc_ready", sb.alloc_ready_o, q.size() != DEPTH);
        check("mem_valid", sb.mem_valid_o, nc > 0);
        if (nc > 0) begin
            check("mem_addr", sb.mem_addr_o, q[0].a);
            check("mem_data", sb.mem_data_o, q[0].d);
            check("mem_strb", sb.mem_strb_o, q[0].s);
        end
        check("ld_hit", sb.ld_hit_o, eh);
        check("ld_data", sb.ld_data_o, ed);
        check("ld_strb", sb.ld_strb_o, es);
    endtask

    task automatic reset_model();
        q.delete();
        nc = 0;
        eh = 1'b0;
        ed = '0;
        es = '0;
    endtask

    // one clock: drive inputs, advance the model, then check after the edge
    task automatic cycle(input bit av, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit cm, input bit fl, input bit mr, input bit lv, input logic [31:0] la);
        int   cnt;
        bit   was_full, drain, comm;
        ent_t e;
        sb.alloc_valid_i = av;
        sb.alloc_addr_i  = a;
        sb.alloc_data_i  = d;
        sb.alloc_strb_i  = s;
        sb.commit_i      = cm;
        sb.flush_i       = fl;
        sb.mem_ready_i   = mr;
        sb.ld_valid_i    = lv;
        sb.ld_addr_i     = la;
        #1;
        if (sb.mem_valid_o && mr) dut_wr++;
        cnt      = q.size();
        was_full = cnt == DEPTH;
        eh = 1'b0;
        ed = '0;
        es = '0;
        if (FWD && lv)
            for (int i = 0; i < cnt; i++)
                if (q[i].a[31:2] == la[31:2]) begin
                    eh = 1'b1;
                    ed = q[i].d;
                    es = q[i].s;
                end
        drain = nc > 0 && mr;
        comm  = cm && nc < cnt;
        if (drain) e = q.pop_front();
        nc = nc - int'(drain) + int'(comm);
        if (fl) begin
            while (q.size() > nc) e = q.pop_back();
        end else if (av && !was_full) begin
            e.a = a;
            e.d = d;
            e.s = s;
            q.push_back(e);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_all();
    endtask

    task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cycle(1'b1, a, d, s, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic ctl(input bit cm, input bit fl, input bit mr);
        cycle(1'b0, '0, '0, '0, cm, fl, mr, 1'b0, '0);
    endtask

    initial begin
        int w0;
        n_chk = 0;
        n_pass = 0;
        dut_wr = 0;
        reset_model();
        sb.alloc_valid_i = 1'b0;
        sb.alloc_addr_i  = '0;
        sb.alloc_data_i  = '0;
        sb.alloc_strb_i  = '0;
        sb.commit_i      = 1'b0;
        sb.flush_i       = 1'b0;
        sb.mem_ready_i   = 1'b0;
        sb.ld_valid_i    = 1'b0;
        sb.ld_addr_i     = '0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        check_all();

        for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(4 * i), 32'(i), 4'hf);
        check("fill_count", sb.count_o, 8);
        check("fill_full", sb.full_o, 1);
        check("fill_ready", sb.alloc_ready_o, 0);
        alloc(32'h2000, 32'hdead, 4'hf);
        check("fill_9th_count", sb.count_o, 8);
        ctl(1'b0, 1'b1, 1'b0);
        check("fill_flush_empty", sb.empty_o, 1);

        alloc(32'h100, 32'haa, 4'hf);
        alloc(32'h104, 32'hbb, 4'hf);
        ctl(1'b1, 1'b0, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ctl(1'b0, 1'b0, 1'b0);
            check("drain_hold_addr", sb.mem_addr_o, 32'h100);
        end
        ctl(1'b0, 1'b0, 1'b1);
        check("drain_second_addr", sb.mem_addr_o, 32'h104);
        check("drain_second_data", sb.mem_data_o, 32'hbb);
        ctl(1'b0, 1'b0, 1'b1);
        check("drain_empty", sb.empty_o, 1);

        cycle(1'b1, 32'h200, 32'h11, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h200, 32'h22, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h202);
        check("fwd_hit", sb.ld_hit_o, FWD);
        check("fwd_data", sb.ld_data_o, FWD ? 32'h22 : 32'h0);
        check("fwd_strb", sb.ld_strb_o, FWD ? 4'h3 : 4'h0);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h208);
        check("fwd_miss", sb.ld_hit_o, 0);
        ctl(1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) alloc(32'h300 + 32'(4 * i), 32'h30 + 32'(i), 4'hf);
        ctl(1'b1, 1'b0, 1'b0);
        ctl(1'b1, 1'b1, 1'b0);
        check("flush_count", sb.count_o, 2);
        w0 = dut_wr;
        repeat (4) ctl(1'b0, 1'b0, 1'b1);
        check("flush_writes", dut_wr - w0, 2);
        check("flush_empty", sb.empty_o, 1);

        for (int i = 0; i < 20; i++) begin
            cycle(i % 2 == 0, 32'h400 + 32'(4 * i), 32'(i), 4'hf, i % 2 == 1, 1'b0, 1'b1, 1'b0, '0);
            check("wrap_count_le1", sb.count_o <= 1, 1);
        end
        ctl(1'b0, 1'b0, 1'b1);
        check("wrap_empty", sb.empty_o, 1);

        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 9) < 6, 32'h500 + 32'($urandom_range(0, 15)), $urandom, 4'($urandom),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 32'h500 + 32'($urandom_range(0, 15)));

        repeat (10) ctl(1'b0, 1'b1, 1'b1);
        alloc(32'h600, 32'h66, 4'hf);
        ctl(1'b1, 1'b0, 1'b0);
        check("pre_reset_valid", sb.mem_valid_o, 1);
        #2 reset_n_i = 1'b0;
        #1;
        check("reset_valid", sb.mem_valid_o, 0);
        check("reset_empty", sb.empty_o, 1);
        check("reset_count", sb.count_o, 0);
        reset_model();
        #1 reset_n_i = 1'b1;
        ctl(1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
